// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder.
// Holds the bus widths and the protocol FSM state encoding used by the top.
package i2c_pkg;

  localparam int ADDR_W = 7;  // I2C target address width
  localparam int BYTE_W = 8;  // bus byte / register width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: brings SCL/SDA into the aclk domain and flags bus events.
//   aclk      : system clock
//   aresetn   : synchronous active-low reset (flops reset to 1 = idle bus)
//   scl_in    : raw SCL from the pins, asynchronous
//   sda_in    : raw SDA from the pins, asynchronous
//   sda       : synchronized SDA level
//   scl_rise  : one-cycle flag, synchronized SCL went 0 -> 1
//   scl_fall  : one-cycle flag, synchronized SCL went 1 -> 0
//   start_det : SDA fell while synchronized SCL is high
//   stop_det  : SDA rose while synchronized SCL is high
module i2c_bus_sync #(
  parameter int FILT_LEN = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [FILT_LEN-1:0] scl_sync;
  logic [FILT_LEN-1:0] sda_sync;
  logic                scl_hist;
  logic                sda_hist;
  logic                scl_s;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync[0] <= scl_in;
      sda_sync[0] <= sda_in;
      for (int i = 1; i < FILT_LEN; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_hist <= scl_sync[FILT_LEN-1];
      sda_hist <= sda_sync[FILT_LEN-1];
    end
  end

  assign scl_s     = scl_sync[FILT_LEN-1];
  assign sda       = sda_sync[FILT_LEN-1];
  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  assign start_det = scl_s & sda_hist & ~sda;
  assign stop_det  = scl_s & ~sda_hist & sda;

endmodule

// File: rtl/i2c_target_resp.sv
// I2C target that exposes a byte-addressed register file.
// A write transaction sets the register pointer with its first data byte and
// writes every following byte at the pointer (auto-increment). A read returns
// bytes from the pointer onward, also auto-incrementing.
//   ACLK      : system clock, all flops rising edge
//   ARESETn   : synchronous active-low reset
//   SCL_i     : bus clock from the master (asynchronous)
//   SDA_i     : bus data (asynchronous)
//   SDA_o     : open-drain control, 0 = pull SDA low, 1 = release
//   REG_WR_EN : one-cycle write strobe; REG_ADDR/REG_WDATA valid with it
//   REG_ADDR  : register pointer (reads and writes)
//   REG_WDATA : write data
//   REG_RDATA : read data, combinational from REG_ADDR
//   BUSY      : high between a detected START and a detected STOP
//   ADDR_HIT  : one-cycle pulse when the address byte matches SLAVE_ADDR
module i2c_target_resp
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50,
  parameter int                FILT_LEN   = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              SCL_i,
  input  logic              SDA_i,
  output logic              SDA_o,
  output logic              REG_WR_EN,
  output logic [BYTE_W-1:0] REG_ADDR,
  output logic [BYTE_W-1:0] REG_WDATA,
  input  logic [BYTE_W-1:0] REG_RDATA,
  output logic              BUSY,
  output logic              ADDR_HIT
);

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(.FILT_LEN(FILT_LEN)) u_bus_sync (
    .aclk      (ACLK),
    .aresetn   (ARESETn),
    .scl_in    (SCL_i),
    .sda_in    (SDA_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              rw;          // R/W bit of the matched address byte
  logic              first_byte;  // next write byte is the pointer
  logic              ack_seen;    // master ACKed the byte just read
  logic [BYTE_W-1:0] ptr;

  assign REG_ADDR = ptr;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ack_seen   <= 1'b0;
      ptr        <= '0;
      SDA_o      <= 1'b1;
      REG_WR_EN  <= 1'b0;
      REG_WDATA  <= '0;
      BUSY       <= 1'b0;
      ADDR_HIT   <= 1'b0;
    end else begin
      REG_WR_EN <= 1'b0;
      ADDR_HIT  <= 1'b0;
      // The pointer moves only after the strobe cycle so REG_ADDR is the
      // write target while REG_WR_EN is high. No SCL edge can land in the
      // cycle right after a strobe, so this never collides with the FSM.
      if (REG_WR_EN) ptr <= ptr + 1'b1;

      // Bus conditions outrank SCL edges and are honoured in every state.
      if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= 4'd0;
        ack_seen <= 1'b0;
        BUSY     <= 1'b1;
        SDA_o    <= 1'b1;
      end else if (stop_det) begin
        state <= ST_IDLE;
        BUSY  <= 1'b0;
        SDA_o <= 1'b1;
      end else begin
        case (state)
          ST_ADDR, ST_WR_BYTE: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[BYTE_W-2:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ST_ADDR) begin
                if (shreg[BYTE_W-1:1] == SLAVE_ADDR) begin
                  SDA_o    <= 1'b0;
                  ADDR_HIT <= 1'b1;
                  rw       <= shreg[0];
                  state    <= ST_ADDR_ACK;
                end else begin
                  SDA_o <= 1'b1;
                  state <= ST_WAIT_STOP;
                end
              end else begin
                SDA_o <= 1'b0;
                state <= ST_WR_ACK;
                if (first_byte) begin
                  ptr        <= shreg;
                  first_byte <= 1'b0;
                end else begin
                  REG_WR_EN <= 1'b1;
                  REG_WDATA <= shreg;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (!rw) begin
                SDA_o      <= 1'b1;
                first_byte <= 1'b1;
                state      <= ST_WR_BYTE;
              end else begin
                shreg <= REG_RDATA;
                SDA_o <= REG_RDATA[BYTE_W-1];
                state <= ST_RD_BYTE;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              SDA_o <= 1'b1;
              state <= ST_WR_BYTE;
            end
          end
          ST_RD_BYTE: begin
            // bit_cnt counts bits already completed on the bus; the MSB was
            // put out on the fall that entered this state.
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                SDA_o   <= 1'b1;
                ptr     <= ptr + 1'b1;
                bit_cnt <= 4'd0;
                state   <= ST_RD_ACK;
              end else begin
                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                SDA_o   <= shreg[BYTE_W-2];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda) ack_seen <= 1'b1;
              else      state    <= ST_WAIT_STOP;
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              shreg    <= REG_RDATA;
              SDA_o    <= REG_RDATA[BYTE_W-1];
              bit_cnt  <= 4'd0;
              state    <= ST_RD_BYTE;
            end
          end
          default: ;  // IDLE and WAIT_STOP only react to START/STOP
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_resp.sv
// Bench for i2c_target_resp: a task-driven I2C master on a wired-AND SDA line,
// a register-file read model, and a write scoreboard fed by a strobe monitor.
`timescale 1ns/1ps
module tb_i2c_target_resp;

  localparam int Q    = 10;  // quarter SCL period in aclk cycles
  localparam int FILT = 2;

  // clock / reset
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // bus and DUT signals
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_o, reg_wr_en, busy, addr_hit;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       sda_line;

  assign sda_line = sda_m & sda_o;

  function automatic logic [7:0] reg_model(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  assign reg_rdata = reg_model(reg_addr);

  i2c_target_resp #(.SLAVE_ADDR(7'h50), .FILT_LEN(FILT)) dut (
    .ACLK      (aclk),
    .ARESETn   (aresetn),
    .SCL_i     (scl_m),
    .SDA_i     (sda_line),
    .SDA_o     (sda_o),
    .REG_WR_EN (reg_wr_en),
    .REG_ADDR  (reg_addr),
    .REG_WDATA (reg_wdata),
    .REG_RDATA (reg_rdata),
    .BUSY      (busy),
    .ADDR_HIT  (addr_hit)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  rd_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int hit_cnt = 0;
  int low_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (reg_wr_en) got_q.push_back({reg_addr, reg_wdata});
    if (addr_hit) hit_cnt++;
    if (!sda_o) low_cnt++;
  end

  task automatic drain(input string tag);
    wait_cyc(4);
    check({tag, "_wr_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_wr"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wait_cyc(Q);
      scl_m = 1'b1; wait_cyc(2 * Q);
      scl_m = 1'b0; wait_cyc(Q);
    end
  endtask

  // lat: aclk cycles from the last data-bit SCL fall to SDA_o going low
  task automatic write_byte(input logic [7:0] b, output logic ack, output int lat);
    lat = 0;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_cyc(Q);
      scl_m = 1'b1; wait_cyc(2 * Q);
      scl_m = 1'b0;
      for (int k = 1; k <= Q; k++) begin
        @(negedge aclk);
        if (i == 0 && lat == 0 && !sda_o) lat = k;
      end
    end
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    ack = sda_line; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = '0;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_cyc(Q); scl_m = 1'b1;
      wait_cyc(Q); d[i] = sda_line;
      wait_cyc(Q); scl_m = 1'b0;
    end
    wait_cyc(Q); sda_m = nack;
    wait_cyc(Q); scl_m = 1'b1;
    wait_cyc(2 * Q); scl_m = 1'b0;
    wait_cyc(Q); sda_m = 1'b1;
  endtask

  task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d);
    logic ack;
    int lat;
    i2c_start();
    write_byte(8'hA0, ack, lat); check("txn_addr_ack", ack, 1'b0);
    write_byte(ptr, ack, lat);   check("txn_ptr_ack", ack, 1'b0);
    exp_q.push_back({ptr, d});
    write_byte(d, ack, lat);     check("txn_data_ack", ack, 1'b0);
    i2c_stop();
  endtask

  // watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    logic       ack;
    logic [7:0] d;
    int         lat;
    int         h0;
    int         l0;

    aresetn = 1'b0;
    wait_cyc(5);
    check("reset_outs", {sda_o, reg_wr_en, addr_hit, busy, reg_addr, reg_wdata},
          {1'b1, 3'b000, 16'h0000});
    aresetn = 1'b1;
    wait_cyc(5);

    // register write with auto-increment
    h0 = hit_cnt;
    i2c_start();
    check("busy_after_start", busy, 1'b1);
    exp_q.push_back({8'h10, 8'h5A});
    exp_q.push_back({8'h11, 8'hC3});
    write_byte(8'hA0, ack, lat);
    check("wr_addr_ack", ack, 1'b0);
    check("ack_latency", lat, FILT + 1);
    write_byte(8'h10, ack, lat); check("wr_ptr_ack", ack, 1'b0);
    write_byte(8'h5A, ack, lat); check("wr_d0_ack", ack, 1'b0);
    write_byte(8'hC3, ack, lat); check("wr_d1_ack", ack, 1'b0);
    i2c_stop();
    drain("write");
    check("wr_hits", hit_cnt - h0, 1);
    check("busy_after_stop", busy, 1'b0);
    check("ptr_after_stop", reg_addr, 8'h12);

    // pointer set, repeated START, read two bytes
    h0 = hit_cnt;
    i2c_start();
    write_byte(8'hA0, ack, lat); check("rd_waddr_ack", ack, 1'b0);
    write_byte(8'h20, ack, lat); check("rd_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack, lat); check("rd_raddr_ack", ack, 1'b0);
    rd_q.push_back(reg_model(8'h20));
    rd_q.push_back(reg_model(8'h21));
    read_byte(1'b0, d); check("rd_byte0", d, rd_q.pop_front());
    read_byte(1'b1, d); check("rd_byte1", d, rd_q.pop_front());
    i2c_stop();
    drain("read");
    check("rd_final_ptr", reg_addr, 8'h22);
    check("rd_hits", hit_cnt - h0, 2);

    // wrong address is ignored until STOP
    h0 = hit_cnt;
    l0 = low_cnt;
    i2c_start();
    write_byte(8'h42, ack, lat); check("wa_addr_nack", ack, 1'b1);
    write_byte(8'h10, ack, lat); check("wa_b1_nack", ack, 1'b1);
    write_byte(8'h55, ack, lat); check("wa_b2_nack", ack, 1'b1);
    check("wa_busy", busy, 1'b1);
    i2c_stop();
    drain("wrong_addr");
    check("wa_no_pull", low_cnt - l0, 0);
    check("wa_no_hit", hit_cnt - h0, 0);
    check("wa_ptr_kept", reg_addr, 8'h22);

    // pointer wrap
    i2c_start();
    exp_q.push_back({8'hFF, 8'h11});
    exp_q.push_back({8'h00, 8'h22});
    write_byte(8'hA0, ack, lat); check("wrap_addr_ack", ack, 1'b0);
    write_byte(8'hFF, ack, lat); check("wrap_ptr_ack", ack, 1'b0);
    write_byte(8'h11, ack, lat); check("wrap_d0_ack", ack, 1'b0);
    write_byte(8'h22, ack, lat); check("wrap_d1_ack", ack, 1'b0);
    i2c_stop();
    drain("wrap");
    check("wrap_ptr", reg_addr, 8'h01);

    // reset asserted during the 4th data bit of a write byte
    i2c_start();
    write_byte(8'hA0, ack, lat); check("rst_addr_ack", ack, 1'b0);
    write_byte(8'h30, ack, lat); check("rst_ptr_ack", ack, 1'b0);
    write_bits(8'hB6, 3);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    aresetn = 1'b0;
    wait_cyc(3);
    aresetn = 1'b1;
    wait_cyc(2);
    check("rst_sda_released", sda_o, 1'b1);
    check("rst_busy_clear", busy, 1'b0);
    check("rst_ptr_clear", reg_addr, 8'h00);
    wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
    i2c_stop();
    drain("reset_mid");
    write_txn(8'h40, 8'h77);
    drain("after_reset");

    // STOP in the middle of a write byte
    i2c_start();
    write_byte(8'hA0, ack, lat); check("sm_addr_ack", ack, 1'b0);
    write_byte(8'h50, ack, lat); check("sm_ptr_ack", ack, 1'b0);
    write_bits(8'hF0, 4);
    i2c_stop();
    wait_cyc(4);
    check("sm_busy_clear", busy, 1'b0);
    check("sm_sda_released", sda_o, 1'b1);
    drain("stop_mid");
    check("sm_ptr_kept", reg_addr, 8'h50);
    write_txn(8'h60, 8'hAB);
    drain("after_stop_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
